// File: rtl/sobel_loop_pipe_ctrl.sv
// ============================================================================
// Module      : sobel_loop_pipe_ctrl
// Description : ap_ctrl_chain responder for one flattened, pipelined 2-D loop;
//               issues (row,col) iterations, tracks stages and drains.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_loop_pipe_ctrl #(
    parameter int ROWS_W = 11,
    parameter int COLS_W = 11,
    parameter int DEPTH  = 10
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic                       ap_start,
    input  logic                       ap_continue,
    input  logic [ROWS_W-1:0]          num_rows,
    input  logic [COLS_W-1:0]          num_cols,
    input  logic                       stall,
    output logic                       ap_ready,
    output logic                       ap_done,
    output logic                       ap_idle,
    output logic                       iter_issue,
    output logic [ROWS_W-1:0]          iter_row,
    output logic [COLS_W-1:0]          iter_col,
    output logic                       iter_last,
    output logic                       iter_retire,
    output logic [ROWS_W+COLS_W-1:0]   retire_cnt,
    output logic [1:0]                 cur_state,
    output logic [DEPTH-1:0]           en_vec
);

    localparam int CNT_W = ROWS_W + COLS_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q,      state_d;
    logic [DEPTH-1:0]    en_vec_q,     en_vec_d;
    logic [ROWS_W-1:0]   row_q,        row_d;
    logic [COLS_W-1:0]   col_q,        col_d;
    logic [ROWS_W-1:0]   nr_q,         nr_d;
    logic [COLS_W-1:0]   nc_q,         nc_d;
    logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;

    logic w_accept;
    logic w_zero_trip;
    logic w_row_last;
    logic w_col_last;
    logic w_at_last;
    logic w_issue_go;
    logic w_flush_empty;
    logic w_retire;
    logic w_advance;

    always_comb begin
        w_accept      = (state_q == S_IDLE) && ap_start && !stall;
        w_zero_trip   = (num_rows == '0) || (num_cols == '0);
        w_row_last    = (row_q == (nr_q - 1'b1));
        w_col_last    = (col_q == (nc_q - 1'b1));
        w_at_last     = w_row_last && w_col_last;
        w_issue_go    = (state_q == S_RUN) && en_vec_q[0] && !stall;
        w_flush_empty = en_vec_q[DEPTH-1] && (en_vec_q[DEPTH-2:0] == '0);
        w_retire      = en_vec_q[DEPTH-1] && !stall;
        // DONE waits only on ap_continue, so the stage register keeps moving there.
        w_advance     = !stall || (state_q == S_DONE);
    end

    always_comb begin
        state_d      = state_q;
        en_vec_d     = en_vec_q;
        row_d        = row_q;
        col_d        = col_q;
        nr_d         = nr_q;
        nc_d         = nc_q;
        retire_cnt_d = retire_cnt_q;
        ap_ready     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_zero_trip) begin
                        state_d  = S_DONE;
                        ap_ready = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_issue_go && w_at_last) begin
                    state_d  = S_FLUSH;
                    ap_ready = 1'b1;
                end
            end
            S_FLUSH: begin
                if (w_flush_empty && !stall) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ap_continue) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_accept) begin
            nr_d         = num_rows;
            nc_d         = num_cols;
            row_d        = '0;
            col_d        = '0;
            retire_cnt_d = '0;
        end else begin
            // Indices stop on the last iteration rather than wrapping past it.
            if (w_issue_go && !w_at_last) begin
                if (w_col_last) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            if (w_retire && !(&retire_cnt_q)) begin
                retire_cnt_d = retire_cnt_q + 1'b1;
            end
        end

        if (w_advance) begin
            en_vec_d = {en_vec_q[DEPTH-2:0], (state_d == S_RUN)};
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= S_IDLE;
            en_vec_q     <= '0;
            row_q        <= '0;
            col_q        <= '0;
            nr_q         <= '0;
            nc_q         <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            en_vec_q     <= en_vec_d;
            row_q        <= row_d;
            col_q        <= col_d;
            nr_q         <= nr_d;
            nc_q         <= nc_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_comb begin
        ap_done     = (state_q == S_DONE);
        ap_idle     = (state_q == S_IDLE);
        iter_issue  = en_vec_q[0];
        iter_row    = row_q;
        iter_col    = col_q;
        iter_last   = en_vec_q[0] && w_at_last;
        iter_retire = w_retire;
        retire_cnt  = retire_cnt_q;
        cur_state   = state_q;
        en_vec      = en_vec_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_sobel_loop_pipe_ctrl.sv
// ============================================================================
// Module      : tb_sobel_loop_pipe_ctrl
// Description : Directed bench for sobel_loop_pipe_ctrl (DEPTH=10 and DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sobel_loop_pipe_ctrl;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_continue;
    logic [10:0] num_rows;
    logic [10:0] num_cols;
    logic        stall;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_idle;
    logic        iter_issue;
    logic [10:0] iter_row;
    logic [10:0] iter_col;
    logic        iter_last;
    logic        iter_retire;
    logic [21:0] retire_cnt;
    logic [1:0]  cur_state;
    logic [9:0]  en_vec;

    logic        start2;
    logic [10:0] nr2;
    logic [10:0] nc2;
    logic        ready2;
    logic        done2;
    logic        idle2;
    logic        issue2;
    logic [10:0] row2;
    logic [10:0] col2;
    logic        last2;
    logic        retire2;
    logic [21:0] rcnt2;
    logic [1:0]  state2;
    logic [1:0]  en_vec2;

    int n_checks = 0;
    int n_errs   = 0;

    sobel_loop_pipe_ctrl #(.ROWS_W(11), .COLS_W(11), .DEPTH(10)) u_dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_continue(ap_continue), .num_rows(num_rows), .num_cols(num_cols),
        .stall(stall), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
        .iter_issue(iter_issue), .iter_row(iter_row), .iter_col(iter_col),
        .iter_last(iter_last), .iter_retire(iter_retire), .retire_cnt(retire_cnt),
        .cur_state(cur_state), .en_vec(en_vec)
    );

    sobel_loop_pipe_ctrl #(.ROWS_W(11), .COLS_W(11), .DEPTH(2)) u_dut2 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(start2),
        .ap_continue(ap_continue), .num_rows(nr2), .num_cols(nc2),
        .stall(stall), .ap_ready(ready2), .ap_done(done2), .ap_idle(idle2),
        .iter_issue(issue2), .iter_row(row2), .iter_col(col2),
        .iter_last(last2), .iter_retire(retire2), .retire_cnt(rcnt2),
        .cur_state(state2), .en_vec(en_vec2)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    // One unstalled run of nr x nc on the DEPTH=10 instance with ap_continue=1.
    task automatic run_plain(input int nr, input int nc);
        int n;
        n = nr * nc;
        num_rows = 11'(nr);
        num_cols = 11'(nc);
        ap_start = 1'b1;
        #1;
        chk("t0_idle", 64'(ap_idle), 64'd1);
        chk("t0_ready", 64'(ap_ready), 64'd0);
        for (int k = 1; k <= n + 11; k++) begin
            cyc();
            ap_start = 1'b0;
            #1;
            chk($sformatf("issue_k%0d", k), 64'(iter_issue), 64'((k >= 1) && (k <= n)));
            chk($sformatf("ready_k%0d", k), 64'(ap_ready), 64'(k == n));
            chk($sformatf("done_k%0d", k), 64'(ap_done), 64'(k == n + 10));
            chk($sformatf("retire_k%0d", k), 64'(iter_retire), 64'((k >= 10) && (k <= n + 9)));
            if (k <= n) begin
                chk($sformatf("row_k%0d", k), 64'(iter_row), 64'((k - 1) / nc));
                chk($sformatf("col_k%0d", k), 64'(iter_col), 64'((k - 1) % nc));
                chk($sformatf("last_k%0d", k), 64'(iter_last), 64'(k == n));
                chk($sformatf("state_run_k%0d", k), 64'(cur_state), 64'd1);
            end else if (k < n + 10) begin
                chk($sformatf("state_flush_k%0d", k), 64'(cur_state), 64'd2);
            end else if (k == n + 10) begin
                chk("retire_cnt_done", 64'(retire_cnt), 64'(n));
            end else begin
                chk("back_idle", 64'(cur_state), 64'd0);
            end
        end
    endtask

    int retires;

    initial begin
        ap_rst_n    = 1'b0;
        ap_start    = 1'b0;
        ap_continue = 1'b1;
        num_rows    = '0;
        num_cols    = '0;
        stall       = 1'b0;
        start2      = 1'b0;
        nr2         = '0;
        nc2         = '0;

        // Reset state
        cyc();
        cyc();
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_state", 64'(cur_state), 64'd0);
        chk("rst_en_vec", 64'(en_vec), 64'd0);
        chk("rst_done", 64'(ap_done), 64'd0);
        chk("rst_ready", 64'(ap_ready), 64'd0);
        chk("rst_issue", 64'(iter_issue), 64'd0);
        chk("rst_retire_cnt", 64'(retire_cnt), 64'd0);
        chk("rst_row", 64'(iter_row), 64'd0);
        ap_rst_n = 1'b1;
        cyc();

        // 3x4 run, no stall
        run_plain(3, 4);

        // 3x4 run with 5 stall cycles in RUN and 3 in FLUSH
        cyc();
        retires  = 0;
        num_rows = 11'd3;
        num_cols = 11'd4;
        for (int k = 0; k <= 31; k++) begin
            if (k > 0) cyc();
            ap_start = (k == 0);
            stall    = ((k >= 5) && (k <= 9)) || ((k >= 20) && (k <= 22));
            #1;
            if (iter_retire) retires++;
            chk($sformatf("st_ready_k%0d", k), 64'(ap_ready), 64'(k == 17));
            chk($sformatf("st_done_k%0d", k), 64'(ap_done), 64'(k == 30));
            if (k == 7) begin
                chk("st_issue_frozen", 64'(iter_issue), 64'd1);
                chk("st_row_frozen", 64'(iter_row), 64'd1);
                chk("st_col_frozen", 64'(iter_col), 64'd0);
                chk("st_en_vec_run", 64'(en_vec), 64'h01F);
            end
            if (k == 10) chk("st_en_vec_resume", 64'(en_vec), 64'h01F);
            if (k == 21) chk("st_no_retire_stalled", 64'(iter_retire), 64'd0);
            if (k == 22) chk("st_en_vec_flush", 64'(en_vec), 64'h3F8);
            if (k == 29) chk("st_en_vec_tail", 64'(en_vec), 64'h200);
            if (k == 30) chk("st_retire_cnt", 64'(retire_cnt), 64'd12);
            if (k == 31) chk("st_back_idle", 64'(cur_state), 64'd0);
        end
        chk("st_retire_pulses", 64'(retires), 64'd12);

        // Zero trip count: nr=0, nc=7
        cyc();
        num_rows = 11'd0;
        num_cols = 11'd7;
        ap_start = 1'b1;
        #1;
        chk("z_ready_t0", 64'(ap_ready), 64'd1);
        chk("z_issue_t0", 64'(iter_issue), 64'd0);
        cyc();
        ap_start = 1'b0;
        #1;
        chk("z_done_t1", 64'(ap_done), 64'd1);
        chk("z_issue_t1", 64'(iter_issue), 64'd0);
        chk("z_retire_cnt", 64'(retire_cnt), 64'd0);
        cyc();
        chk("z_idle_t2", 64'(ap_idle), 64'd1);

        // ap_continue held low after done, ap_start held high throughout
        cyc();
        num_rows    = 11'd1;
        num_cols    = 11'd2;
        ap_continue = 1'b0;
        ap_start    = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) cyc();
            ap_continue = (k == 18);
            #1;
            if (k == 5)  chk("c_no_done_run", 64'(ap_done), 64'd0);
            if ((k >= 12) && (k <= 18)) chk($sformatf("c_done_held_k%0d", k), 64'(ap_done), 64'd1);
            if (k == 13) chk("c_start_ignored_done", 64'(cur_state), 64'd3);
            if (k == 19) begin
                chk("c_idle_again", 64'(ap_idle), 64'd1);
                chk("c_ready_idle", 64'(ap_ready), 64'd0);
            end
            if (k == 20) begin
                chk("c_rerun_state", 64'(cur_state), 64'd1);
                chk("c_rerun_issue", 64'(iter_issue), 64'd1);
                chk("c_rerun_col", 64'(iter_col), 64'd0);
            end
        end
        ap_start    = 1'b0;
        ap_continue = 1'b1;
        for (int k = 0; k < 13; k++) cyc();
        chk("c_rerun_finished", 64'(ap_idle), 64'd1);

        // Reset pulse during RUN at row 1
        num_rows = 11'd3;
        num_cols = 11'd4;
        ap_start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            ap_start = 1'b0;
        end
        #1;
        chk("r_row_before", 64'(iter_row), 64'd1);
        ap_rst_n = 1'b0;
        #1;
        chk("r_state", 64'(cur_state), 64'd0);
        chk("r_en_vec", 64'(en_vec), 64'd0);
        chk("r_idle", 64'(ap_idle), 64'd1);
        cyc();
        ap_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("r_no_done_%0d", k), 64'(ap_done), 64'd0);
        end
        run_plain(3, 4);

        // DEPTH=2 instance, 1x1 run
        cyc();
        nr2    = 11'd1;
        nc2    = 11'd1;
        start2 = 1'b1;
        #1;
        chk("d2_ready_t0", 64'(ready2), 64'd0);
        cyc();
        start2 = 1'b0;
        #1;
        chk("d2_ready_t1", 64'(ready2), 64'd1);
        chk("d2_last_t1", 64'(last2), 64'd1);
        chk("d2_issue_t1", 64'(issue2), 64'd1);
        cyc();
        chk("d2_en_vec_t2", 64'(en_vec2), 64'd2);
        chk("d2_retire_t2", 64'(retire2), 64'd1);
        chk("d2_done_t2", 64'(done2), 64'd0);
        cyc();
        chk("d2_done_t3", 64'(done2), 64'd1);
        chk("d2_retire_cnt", 64'(rcnt2), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
